// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache fills and dcache fills/write-backs onto one
// block-wide memory port using the caches' read/write/busywait handshake.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break IDLE ties by
// alternating ports; otherwise the dcache always wins a tie.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_readdata,
  output logic                  i_busywait,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_writedata,
  output logic [DATA_WIDTH-1:0] d_readdata,
  output logic                  d_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_writedata_q, mem_writedata_d;
  logic [DATA_WIDTH-1:0]   i_readdata_q, i_readdata_d;
  logic [DATA_WIDTH-1:0]   d_readdata_q, d_readdata_d;

  logic i_req, d_req, tie_pick_d, pick_d;

  // Stall each cache until its acknowledge (RESP) cycle.
  assign i_req      = i_read;
  assign d_req      = d_read | d_write;
  assign i_busywait = i_req & (state_q != RESP_I);
  assign d_busywait = d_req & (state_q != RESP_D);

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign i_readdata    = i_readdata_q;
  assign d_readdata    = d_readdata_q;

  // Tie-break choice when both caches request in IDLE.
  always_comb begin
    tie_pick_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_pick_d = (last_grant_q == GRANT_I);
`endif
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    i_readdata_d    = i_readdata_q;
    d_readdata_d    = d_readdata_q;
    pick_d          = (i_req & d_req) ? tie_pick_d : d_req;

    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          if (pick_d) begin
            // Read+write together is served as a write.
            state_d         = SERVE_D;
            last_grant_d    = GRANT_D;
            mem_write_d     = d_write;
            mem_read_d      = ~d_write;
            mem_address_d   = d_address;
            mem_writedata_d = d_writedata;
          end else begin
            state_d       = SERVE_I;
            last_grant_d  = GRANT_I;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
            mem_address_d = i_address;
          end
        end
      end
      SERVE_I: begin
        if (!mem_busywait) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          i_readdata_d = mem_readdata;
          state_d      = RESP_I;
        end
      end
      SERVE_D: begin
        if (!mem_busywait) begin
          if (mem_read_q) begin
            d_readdata_d = mem_readdata;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP_D;
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      last_grant_q    <= GRANT_I;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      i_readdata_q    <= i_readdata_d;
      d_readdata_q    <= d_readdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed traffic against a memory model
// of configurable latency, with a scoreboard of expected grants and acks.
module tb_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam logic [DW-1:0] POISON   = {4{32'hBAD0_BAD0}};
  localparam logic [DW-1:0] T1_BLOCK = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [DW-1:0] WB_BLOCK = 128'hDEAD_BEEF_0000_1111_2222_3333_DEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;

  grant_t        exp_g[$];
  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_d[$];
  logic [DW-1:0] i_model = '0;
  logic [DW-1:0] d_model = '0;

  mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_busywait   (i_busywait),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_readdata   (d_readdata),
    .d_busywait   (d_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clk = ~clk;

  // Memory contents as a fixed function of block address.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    if (a == 28'h0000010) return T1_BLOCK;
    return {4{4'hA, a}};
  endfunction

  // Memory model: busy from the strobe's first cycle until its lat-th cycle.
  int unsigned lat = 5;
  int unsigned mem_cnt = 0;
  always @(posedge clk) mem_cnt <= (mem_read | mem_write) ? mem_cnt + 1 : 0;
  assign mem_busywait = (mem_read | mem_write) && (mem_cnt + 1 < lat);
  assign mem_readdata = mem_read ? pat(mem_address) : POISON;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_grant(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    grant_t g;
    g.wr = wr; g.addr = a; g.wdata = wd;
    exp_g.push_back(g);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit port_d, input int unsigned maxc);
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if (port_d ? !d_busywait : !i_busywait) break;
      n++;
      if (n >= maxc) begin
        n_vec++; n_err++;
        $display("FAIL ack_timeout: port_d=%0d no ack within %0d cycles", port_d, maxc);
        break;
      end
    end
  endtask

  task automatic wait_any_ack(input int unsigned maxc);
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if ((i_read && !i_busywait) || ((d_read || d_write) && !d_busywait)) break;
      n++;
      if (n >= maxc) begin
        n_vec++; n_err++;
        $display("FAIL ack_timeout: no ack within %0d cycles", maxc);
        break;
      end
    end
  endtask

  task automatic do_reset();
    step(); reset = 1'b0;
    step(); reset = 1'b1;
    i_model = '0; d_model = '0;
  endtask

  // Monitor: checks each new grant and each acknowledge against the scoreboard.
  initial begin
    logic   prev_strobe;
    grant_t g;
    logic [DW-1:0] e;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if ((mem_read || mem_write) && !prev_strobe) begin
        if (exp_g.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_grant: addr %0h wr %0d, none expected", mem_address, mem_write);
        end else begin
          g = exp_g.pop_front();
          chk("grant_strobes", DW'({mem_write, mem_read}), DW'({g.wr, ~g.wr}));
          chk("grant_addr", DW'(mem_address), DW'(g.addr));
          if (g.wr) chk("grant_wdata", mem_writedata, g.wdata);
        end
      end
      if (i_read && !i_busywait) begin
        if (exp_i.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_i_ack: data %0h", i_readdata);
        end else begin
          e = exp_i.pop_front();
          chk("i_ack_data", i_readdata, e);
        end
      end
      if ((d_read || d_write) && !d_busywait) begin
        if (exp_d.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_d_ack: data %0h", d_readdata);
        end else begin
          e = exp_d.pop_front();
          chk("d_ack_data", d_readdata, e);
        end
      end
      prev_strobe = mem_read | mem_write;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) step();
    @(negedge clk);
    chk("rst_mem_read", DW'(mem_read), DW'(1'b0));
    chk("rst_mem_write", DW'(mem_write), DW'(1'b0));
    chk("rst_mem_address", DW'(mem_address), '0);
    chk("rst_mem_writedata", mem_writedata, '0);
    chk("rst_i_readdata", i_readdata, '0);
    chk("rst_d_readdata", d_readdata, '0);
    chk("rst_busywaits", DW'({i_busywait, d_busywait}), '0);
    step(); reset = 1'b1;

    // Single icache read, latency 5.
    lat = 5;
    push_grant(1'b0, 28'h0000010, '0);
    exp_i.push_back(T1_BLOCK);
    step(); i_read = 1'b1; i_address = 28'h0000010;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t1_mem_read_c%0d", k), DW'(mem_read), DW'((k >= 1 && k <= 5) ? 1'b1 : 1'b0));
      chk($sformatf("t1_i_busywait_c%0d", k), DW'(i_busywait), DW'((k != 6) ? 1'b1 : 1'b0));
    end
    step(); i_read = 1'b0;
    i_model = T1_BLOCK;
    @(negedge clk);
    chk("t1_idle_mem_read", DW'(mem_read), DW'(1'b0));
    chk("t1_i_readdata_hold", i_readdata, i_model);

    // dcache read, then write-back that must leave d_readdata unchanged.
    lat = 2;
    push_grant(1'b0, 28'h00000B0, '0);
    exp_d.push_back(pat(28'h00000B0));
    step(); d_read = 1'b1; d_address = 28'h00000B0;
    wait_ack(1'b1, 50);
    step(); d_read = 1'b0;
    d_model = pat(28'h00000B0);

    lat = 3;
    push_grant(1'b1, 28'h00000A0, WB_BLOCK);
    exp_d.push_back(d_model);
    step(); d_write = 1'b1; d_address = 28'h00000A0; d_writedata = WB_BLOCK;
    wait_ack(1'b1, 50);
    step(); d_write = 1'b0; d_writedata = '0;
    @(negedge clk);
    chk("t2_d_readdata_unchanged", d_readdata, d_model);
    chk("t2_d_busywait_after", DW'(d_busywait), DW'(1'b0));

    // Simultaneous i_read/d_read from reset: D first, I on the following IDLE edge.
    do_reset();
    lat = 2;
    push_grant(1'b0, 28'h00000C0, '0);
    push_grant(1'b0, 28'h0000020, '0);
    exp_d.push_back(pat(28'h00000C0));
    exp_i.push_back(pat(28'h0000020));
    step();
    i_read = 1'b1; i_address = 28'h0000020;
    d_read = 1'b1; d_address = 28'h00000C0;
    fork
      begin wait_ack(1'b1, 50); step(); d_read = 1'b0; end
      begin wait_ack(1'b0, 50); step(); i_read = 1'b0; end
      begin
        for (int k = 0; k <= 7; k++) begin
          @(negedge clk);
          chk($sformatf("t3_i_busywait_c%0d", k), DW'(i_busywait), DW'((k != 7) ? 1'b1 : 1'b0));
          chk($sformatf("t3_mem_read_c%0d", k), DW'(mem_read),
              DW'((k == 1 || k == 2 || k == 5 || k == 6) ? 1'b1 : 1'b0));
        end
      end
    join
    i_model = pat(28'h0000020);
    d_model = pat(28'h00000C0);

    // Continuous ties over four transfers.
    do_reset();
    lat = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int t = 0; t < 2; t++) begin
      push_grant(1'b0, 28'h00000D0, '0); exp_d.push_back(pat(28'h00000D0));
      push_grant(1'b0, 28'h0000030, '0); exp_i.push_back(pat(28'h0000030));
    end
`else
    for (int t = 0; t < 4; t++) begin
      push_grant(1'b0, 28'h00000D0, '0); exp_d.push_back(pat(28'h00000D0));
    end
`endif
    step();
    i_read = 1'b1; i_address = 28'h0000030;
    d_read = 1'b1; d_address = 28'h00000D0;
    for (int t = 0; t < 4; t++) wait_any_ack(50);
    step(); i_read = 1'b0; d_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_grants_consumed", DW'(exp_g.size()), '0);
    d_model = pat(28'h00000D0);

    // Reset mid-SERVE_I, then a fresh transfer with i_read still high.
    lat = 6;
    push_grant(1'b0, 28'h0000040, '0);
    push_grant(1'b0, 28'h0000040, '0);
    exp_i.push_back(pat(28'h0000040));
    step(); i_read = 1'b1; i_address = 28'h0000040;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(); reset = 1'b1;
    @(negedge clk);
    chk("t5_mem_read", DW'(mem_read), DW'(1'b0));
    chk("t5_mem_write", DW'(mem_write), DW'(1'b0));
    chk("t5_mem_address", DW'(mem_address), '0);
    chk("t5_mem_writedata", mem_writedata, '0);
    chk("t5_i_readdata", i_readdata, '0);
    chk("t5_d_readdata", d_readdata, '0);
    chk("t5_i_busywait", DW'(i_busywait), DW'(1'b1));
    wait_ack(1'b0, 50);
    step(); i_read = 1'b0;
    i_model = pat(28'h0000040);
    d_model = '0;

    // i_read dropped during SERVE_I; a dcache read raised in RESP_I waits for IDLE.
    lat = 4;
    push_grant(1'b0, 28'h0000050, '0);
    push_grant(1'b0, 28'h00000E0, '0);
    exp_d.push_back(pat(28'h00000E0));
    step(); i_read = 1'b1; i_address = 28'h0000050;
    step();
    step(); i_read = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t6_mem_read_c%0d", k), DW'(mem_read), DW'(1'b1));
    end
    step(); d_read = 1'b1; d_address = 28'h00000E0;
    @(negedge clk);
    chk("t6_i_readdata", i_readdata, pat(28'h0000050));
    chk("t6_mem_read_resp", DW'(mem_read), DW'(1'b0));
    @(negedge clk);
    chk("t6_mem_read_idle", DW'(mem_read), DW'(1'b0));
    @(negedge clk);
    chk("t6_mem_read_d_grant", DW'(mem_read), DW'(1'b1));
    wait_ack(1'b1, 50);
    step(); d_read = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_grants_left", DW'(exp_g.size()), '0);
    chk("sb_i_left", DW'(exp_i.size()), '0);
    chk("sb_d_left", DW'(exp_d.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
